// File: rtl/activation_unit_fp32_if.sv
// Beat-level handshake bundle for activation_unit_fp32: input beats, output beats
// and the FIFO occupancy debug count.
interface activation_unit_fp32_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                          i_valid;
    logic                          i_ready;
    logic [LANES*DATA_WIDTH-1:0]   i_data;
    logic [1:0]                    i_mode;
    logic [DATA_WIDTH-1:0]         i_alpha;
    logic                          o_valid;
    logic                          o_ready;
    logic [LANES*DATA_WIDTH-1:0]   o_data;
    logic [CW-1:0]                 o_count;

    modport master (
        output i_valid, i_data, i_mode, i_alpha, o_ready,
        input  i_ready, o_valid, o_data, o_count
    );

    modport slave (
        input  i_valid, i_data, i_mode, i_alpha, o_ready,
        output i_ready, o_valid, o_data, o_count
    );
endinterface

// File: rtl/activation_unit_fp32.sv
// FP32 activation stage: identity / ReLU / LeakyReLU per beat. Every lane is
// multiplied by alpha on a fixed-latency, non-stallable path; a sideband shift
// register keeps the original data and mode aligned with the products, and a
// credit-guarded output FIFO absorbs downstream backpressure.

// Fixed-latency FP32 multiplier (round-to-nearest-even, subnormals flushed to zero).
module multiplier_floating_point32 #(
    parameter int LATENCY = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_in,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    output logic        valid_out,
    output logic [31:0] out
);
    logic              sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, g, st;
    logic [7:0]        ea, eb;
    logic [47:0]       prod;
    logic signed [9:0] e;
    logic [22:0]       frac;
    logic [23:0]       rnd;
    logic [31:0]       res;
    logic [LATENCY-1:0] vpipe;
    logic [31:0]       dpipe [LATENCY];

    // Single-cycle product, normalisation and rounding; latency is added behind it.
    always_comb begin
        sign   = inA[31] ^ inB[31];
        ea     = inA[30:23];
        eb     = inB[30:23];
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (inA[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (inB[22:0] == 23'd0);
        a_nan  = (ea == 8'hFF) && (inA[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (inB[22:0] != 23'd0);
        prod   = {1'b1, inA[22:0]} * {1'b1, inB[22:0]};
        e      = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (prod[47]) begin
            frac = prod[46:24];
            g    = prod[23];
            st   = |prod[22:0];
            e    = e + 10'sd1;
        end else begin
            frac = prod[45:23];
            g    = prod[22];
            st   = |prod[21:0];
        end
        rnd = {1'b0, frac} + {23'd0, (g && (st || frac[0]))};
        if (rnd[23]) begin
            e = e + 10'sd1;
        end
        if (a_nan || b_nan) begin
            res = 32'h7FC00000;
        end else if (a_inf || b_inf) begin
            res = (a_zero || b_zero) ? 32'h7FC00000 : {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            res = {sign, 31'd0};
        end else if (e >= 10'sd255) begin
            res = {sign, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            res = {sign, 31'd0};
        end else begin
            res = {sign, e[7:0], rnd[22:0]};
        end
    end

    // Latency pipeline; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vpipe <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) dpipe[i] <= '0;
        end else begin
            vpipe    <= {vpipe[LATENCY-2:0], valid_in};
            dpipe[0] <= res;
            for (int unsigned i = 1; i < LATENCY; i++) dpipe[i] <= dpipe[i-1];
        end
    end

    assign valid_out = vpipe[LATENCY-1];
    assign out       = dpipe[LATENCY-1];
endmodule

module activation_unit_fp32 #(
    parameter int DATA_WIDTH  = 32,
    parameter int LANES       = 4,
    parameter int MUL_LATENCY = 7,
    parameter int FIFO_DEPTH  = 16
) (
    input logic                  clk,
    input logic                  rst,
    activation_unit_fp32_if.slave bus
);
    localparam int BW   = LANES * DATA_WIDTH;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LAST = MUL_LATENCY - 1;

    typedef enum logic [1:0] {MODE_IDENT, MODE_RELU, MODE_LEAKY, MODE_RSVD} mode_e;

    logic                  accept, rstn, wr_en, rd_en;
    logic [LANES-1:0]      mul_valid;
    logic [DATA_WIDTH-1:0] mul_out [LANES];
    logic [BW-1:0]         sb_data [MUL_LATENCY];
    mode_e                 sb_mode [MUL_LATENCY];
    logic [BW-1:0]         sel_data;
    logic [BW-1:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, inflight;
    logic [CW:0]           credit_sum;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rstn       = ~rst;
    assign accept     = bus.i_valid && bus.i_ready;
    assign credit_sum = {1'b0, count} + {1'b0, inflight};
    assign bus.i_ready = !rst && (credit_sum < (CW+1)'(FIFO_DEPTH));

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        multiplier_floating_point32 #(.LATENCY(MUL_LATENCY)) u_mul (
            .clk       (clk),
            .rstn      (rstn),
            .valid_in  (accept),
            .inA       (bus.i_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .inB       (bus.i_alpha),
            .valid_out (mul_valid[k]),
            .out       (mul_out[k])
        );
    end

    // Sideband shift register: original lanes and mode, aligned with the products.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
                sb_data[i] <= '0;
                sb_mode[i] <= MODE_IDENT;
            end
        end else begin
            sb_data[0] <= bus.i_data;
            sb_mode[0] <= mode_e'(bus.i_mode);
            for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                sb_data[i] <= sb_data[i-1];
                sb_mode[i] <= sb_mode[i-1];
            end
        end
    end

    // Per-lane result selection on the original sign bit.
    always_comb begin
        sel_data = sb_data[LAST];
        for (int unsigned k = 0; k < LANES; k++) begin
            if (sb_data[LAST][k*DATA_WIDTH + DATA_WIDTH - 1]) begin
                case (sb_mode[LAST])
                    MODE_RELU:  sel_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                    MODE_LEAKY: sel_data[k*DATA_WIDTH +: DATA_WIDTH] = mul_out[k];
                    default:    ;
                endcase
            end
        end
    end

    // All lanes are issued together, so their valids move in lockstep.
    assign wr_en       = &mul_valid;
    assign rd_en       = bus.o_valid && bus.o_ready;
    assign bus.o_valid = (count != '0);
    assign bus.o_data  = bus.o_valid ? mem[rd_ptr] : '0;
    assign bus.o_count = count;

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sel_data;
    end

    // FIFO pointers, occupancy and in-flight credit tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            case ({accept, wr_en})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end
endmodule
